sfx_arbiter: RTL and testbench

- Shares one square-wave tone generator (piezo/speaker pin) among four game-event requesters from the pong game logic: wall bounce, paddle hit, point scored (ball missed), and game over.
- Latches single-cycle event pulses, grants the tone generator by fixed priority, and times each tone and the inter-tone gap.
- Sits between the game logic event strobes and the audio output pin, in the clk_0 domain.

---
 rtl/sfx_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_sfx_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/sfx_arbiter.sv
// -----------------------------------------------------------------------------
// sfx_arbiter
//
// Shares one square-wave tone generator among four pong sound events. Each
// single-cycle event strobe is latched as a pending request. The highest
// pending request is granted, and that source's tone plays for a fixed
// duration. A silent gap follows every completed tone. A strictly
// higher-priority request cuts the current tone short and plays at once.
// The cut-off tone is not replayed.
//
// Priority: over(3) > miss(2) > paddle(1) > wall(0).
//
// Ports
//   clk_0      in   system clock (CLK_HZ)
//   rst        in   asynchronous, active-low reset
//   ev_wall    in   pulse: ball hit top or bottom wall
//   ev_paddle  in   pulse: ball hit a paddle face
//   ev_miss    in   pulse: point scored
//   ev_over    in   pulse: game over
//   mute       in   level: silences output, drops pending requests
//   tone_out   out  square-wave audio pin
//   busy       out  high while a tone or its trailing gap is in progress
//   active_id  out  source currently or most recently played
//   grant      out  one-cycle pulse on the first cycle of each tone
// -----------------------------------------------------------------------------
module sfx_arbiter #(
  parameter int unsigned CLK_HZ    = 25_175_000,
  parameter int unsigned HP_WALL   = 57_216,
  parameter int unsigned HP_PADDLE = 28_608,
  parameter int unsigned HP_MISS   = 114_432,
  parameter int unsigned HP_OVER   = 14_304,
  parameter int unsigned DUR_SHORT = 1_258_750,
  parameter int unsigned DUR_LONG  = 7_552_500,
  parameter int unsigned GAP       = 251_750
) (
  input  logic       clk_0,
  input  logic       rst,
  input  logic       ev_wall,
  input  logic       ev_paddle,
  input  logic       ev_miss,
  input  logic       ev_over,
  input  logic       mute,
  output logic       tone_out,
  output logic       busy,
  output logic [1:0] active_id,
  output logic       grant
);

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Each counter only ever holds limit-1. Therefore $clog2 of the largest
  // limit is wide enough. The floor of 2 keeps the width at one bit or more
  // when every limit is 1.
  localparam int unsigned HP_MAX  = max_u(max_u(HP_WALL, HP_PADDLE), max_u(HP_MISS, HP_OVER));
  localparam int unsigned DUR_MAX = max_u(DUR_SHORT, DUR_LONG);
  localparam int          HP_W    = $clog2(max_u(HP_MAX, 2));
  localparam int          DUR_W   = $clog2(max_u(DUR_MAX, 2));
  localparam int          GAP_W   = $clog2(max_u(GAP, 2));

  localparam logic [HP_W-1:0]  HP_WALL_L   = HP_W'(HP_WALL - 1);
  localparam logic [HP_W-1:0]  HP_PADDLE_L = HP_W'(HP_PADDLE - 1);
  localparam logic [HP_W-1:0]  HP_MISS_L   = HP_W'(HP_MISS - 1);
  localparam logic [HP_W-1:0]  HP_OVER_L   = HP_W'(HP_OVER - 1);
  localparam logic [DUR_W-1:0] DUR_SHORT_L = DUR_W'(DUR_SHORT - 1);
  localparam logic [DUR_W-1:0] DUR_LONG_L  = DUR_W'(DUR_LONG - 1);
  localparam logic [GAP_W-1:0] GAP_L       = GAP_W'(GAP - 1);

  // CLK_HZ only records the clock rate that the cycle counts above were
  // derived from. A zero-length tone, half-period or gap has no meaning.
  // An illegal set leaves a marker scope in the elaborated hierarchy.
  localparam bit PARAMS_LEGAL = (CLK_HZ > 0) && (HP_WALL >= 1) && (HP_PADDLE >= 1) &&
                                (HP_MISS >= 1) && (HP_OVER >= 1) && (DUR_SHORT >= 1) &&
                                (DUR_LONG >= 1) && (GAP >= 1);
  if (!PARAMS_LEGAL) begin : g_illegal_params
  end

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_t;

  state_t           state;
  logic [3:0]       pend;
  logic [HP_W-1:0]  hp_cnt;
  logic [DUR_W-1:0] dur_cnt;
  logic [GAP_W-1:0] gap_cnt;

  logic [3:0]       ev_vec;
  logic [3:0]       clr;
  logic [3:0]       pend_next;
  logic [1:0]       top_id;
  logic             take;
  logic [HP_W-1:0]  hp_lim;
  logic [DUR_W-1:0] dur_lim;

  assign ev_vec = {ev_over, ev_miss, ev_paddle, ev_wall};

  // NOTE: every signal driven here gets a default at the top of the block.
  // Otherwise a path that skips an assignment would infer a latch.
  always_comb begin
    top_id = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (pend[i]) top_id = 2'(i);
    end

    take = 1'b0;
    case (state)
      S_IDLE:  take = |pend;
      S_PLAY:  take = (|pend) && (top_id > active_id);
      default: take = 1'b0;
    endcase

    // A new strobe from the source that is granted at this edge is absorbed
    // into that grant. The clear therefore wins over the set.
    clr       = take ? (4'b0001 << top_id) : 4'b0000;
    pend_next = (pend | ev_vec) & ~clr;

    hp_lim = HP_WALL_L;
    case (active_id)
      2'd0: hp_lim = HP_WALL_L;
      2'd1: hp_lim = HP_PADDLE_L;
      2'd2: hp_lim = HP_MISS_L;
      2'd3: hp_lim = HP_OVER_L;
      default: hp_lim = HP_WALL_L;
    endcase

    // The miss and over sources (ids 2 and 3) use the long duration.
    dur_lim = active_id[1] ? DUR_LONG_L : DUR_SHORT_L;
  end

  // NOTE: all state uses non-blocking assignments. Every register then
  // sees the values from before the edge, whatever the statement order.
  always_ff @(posedge clk_0 or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      pend      <= '0;
      hp_cnt    <= '0;
      dur_cnt   <= '0;
      gap_cnt   <= '0;
      tone_out  <= 1'b0;
      busy      <= 1'b0;
      active_id <= 2'd0;
      grant     <= 1'b0;
    end else begin
      grant <= 1'b0;
      if (mute) begin
        // Silence immediately and drop everything. Strobes that arrive
        // while muted are never latched.
        state    <= S_IDLE;
        pend     <= '0;
        hp_cnt   <= '0;
        dur_cnt  <= '0;
        gap_cnt  <= '0;
        tone_out <= 1'b0;
        busy     <= 1'b0;
      end else begin
        pend <= pend_next;
        if (take) begin
          // A fresh grant from IDLE, or a preemption from PLAY. The tone
          // always starts on a high half-period.
          state     <= S_PLAY;
          active_id <= top_id;
          grant     <= 1'b1;
          hp_cnt    <= '0;
          dur_cnt   <= '0;
          tone_out  <= 1'b1;
          busy      <= 1'b1;
        end else begin
          case (state)
            S_PLAY: begin
              if (dur_cnt == dur_lim) begin
                state    <= S_GAP;
                gap_cnt  <= '0;
                hp_cnt   <= '0;
                dur_cnt  <= '0;
                tone_out <= 1'b0;
              end else begin
                dur_cnt <= dur_cnt + 1'b1;
                if (hp_cnt == hp_lim) begin
                  hp_cnt   <= '0;
                  tone_out <= ~tone_out;
                end else begin
                  hp_cnt <= hp_cnt + 1'b1;
                end
              end
            end
            S_GAP: begin
              // The gap always runs to full length, even with
              // higher-priority requests pending.
              if (gap_cnt == GAP_L) begin
                state   <= S_IDLE;
                gap_cnt <= '0;
                busy    <= 1'b0;
              end else begin
                gap_cnt <= gap_cnt + 1'b1;
              end
            end
            default: begin
              state    <= S_IDLE;
              tone_out <= 1'b0;
              busy     <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_sfx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sfx_arbiter
//
// Directed bench for sfx_arbiter, using short tone parameters. Each stimulus
// step pushes the grants it expects (source id and cycle) onto a scoreboard.
// A negedge monitor pops an entry for every grant the DUT raises and checks
// it. Tone waveform, busy and reset/mute behaviour are checked inline.
// -----------------------------------------------------------------------------
module tb_sfx_arbiter;

  localparam int T_HP_WALL   = 4;
  localparam int T_HP_PADDLE = 3;
  localparam int T_HP_MISS   = 5;
  localparam int T_HP_OVER   = 2;
  localparam int T_DUR_SHORT = 20;
  localparam int T_DUR_LONG  = 40;
  localparam int T_GAP       = 6;

  localparam logic [3:0] M_WALL   = 4'b0001;
  localparam logic [3:0] M_PADDLE = 4'b0010;
  localparam logic [3:0] M_MISS   = 4'b0100;
  localparam logic [3:0] M_OVER   = 4'b1000;

  logic       clk_0 = 1'b0;
  logic       rst;
  logic       ev_wall, ev_paddle, ev_miss, ev_over, mute;
  logic       tone_out, busy, grant;
  logic [1:0] active_id;

  typedef struct {
    logic [1:0] id;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc      = 0;
  int   n_assert = 0;
  int   n_fail   = 0;

  sfx_arbiter #(
    .HP_WALL  (T_HP_WALL),
    .HP_PADDLE(T_HP_PADDLE),
    .HP_MISS  (T_HP_MISS),
    .HP_OVER  (T_HP_OVER),
    .DUR_SHORT(T_DUR_SHORT),
    .DUR_LONG (T_DUR_LONG),
    .GAP      (T_GAP)
  ) dut (
    .clk_0    (clk_0),
    .rst      (rst),
    .ev_wall  (ev_wall),
    .ev_paddle(ev_paddle),
    .ev_miss  (ev_miss),
    .ev_over  (ev_over),
    .mute     (mute),
    .tone_out (tone_out),
    .busy     (busy),
    .active_id(active_id),
    .grant    (grant)
  );

  always #5 clk_0 = ~clk_0;
  always @(posedge clk_0) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_assert++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  // Grant monitor. Every grant pulse must match the oldest outstanding
  // expectation.
  always @(negedge clk_0) begin
    exp_t e;
    if (grant === 1'b1) begin
      check("grant_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("grant_id", 32'(active_id), 32'(e.id));
        check("grant_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic expect_grant(input logic [1:0] id, input int at);
    sb.push_back('{id: id, cyc: at});
  endtask

  // Called just after a negedge. Drives the strobes for one cycle and
  // reports the cycle they were driven in.
  task automatic pulse(input logic [3:0] m, output int at);
    {ev_over, ev_miss, ev_paddle, ev_wall} = m;
    at = cyc;
    @(negedge clk_0);
    {ev_over, ev_miss, ev_paddle, ev_wall} = 4'b0000;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk_0);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while ((sb.size() != 0 || busy !== 1'b0) && n < budget) begin
      @(negedge clk_0);
      n++;
    end
    check({"drain_", tag}, 32'(n < budget), 32'd1);
    repeat (10) @(negedge clk_0);
  endtask

  initial begin
    int at, g, g2, g3;

    rst = 1'b0;
    mute = 1'b0;
    {ev_over, ev_miss, ev_paddle, ev_wall} = 4'b0000;

    // Outputs while held in reset.
    repeat (2) @(negedge clk_0);
    check("rst_tone_out", 32'(tone_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_active_id", 32'(active_id), 32'd0);
    rst = 1'b1;

    // Single paddle hit: 2-cycle latency, half-period 3, 20 tone cycles,
    // then a 6-cycle gap.
    wait_cyc(10);
    pulse(M_PADDLE, at);
    g = at + 2;
    expect_grant(2'd1, g);
    @(negedge clk_0);
    for (int k = 0; k <= T_DUR_SHORT + T_GAP; k++) begin
      check($sformatf("paddle_tone_k%0d", k), 32'(tone_out),
            32'((k < T_DUR_SHORT) ? (((k / T_HP_PADDLE) % 2) == 0) : 1'b0));
      check($sformatf("paddle_busy_k%0d", k), 32'(busy), 32'(k < T_DUR_SHORT + T_GAP));
      @(negedge clk_0);
    end
    wait_idle("paddle", 50);

    // Three simultaneous sources play in priority order: miss, paddle, wall.
    pulse(M_WALL | M_PADDLE | M_MISS, at);
    g  = at + 2;
    g2 = g + T_DUR_LONG + T_GAP + 1;
    g3 = g2 + T_DUR_SHORT + T_GAP + 1;
    expect_grant(2'd2, g);
    expect_grant(2'd1, g2);
    expect_grant(2'd0, g3);
    wait_cyc(g2 - 1);
    check("multi_gap_tone", 32'(tone_out), 32'd0);
    check("multi_gap_busy", 32'(busy), 32'd0);
    wait_idle("multi", 300);

    // Wall preempted by game over at tone cycle 5. The wall tone is dropped.
    pulse(M_WALL, at);
    g = at + 2;
    expect_grant(2'd0, g);
    wait_cyc(g + 5);
    pulse(M_OVER, at);
    g2 = at + 2;
    expect_grant(2'd3, g2);
    @(negedge clk_0);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("over_tone_k%0d", k), 32'(tone_out), 32'(((k / T_HP_OVER) % 2) == 0));
      check($sformatf("over_id_k%0d", k), 32'(active_id), 32'd3);
      @(negedge clk_0);
    end
    wait_idle("preempt", 200);

    // Three wall strobes during a miss tone merge into one wall tone.
    pulse(M_MISS, at);
    g = at + 2;
    expect_grant(2'd2, g);
    wait_cyc(at + 5);  pulse(M_WALL, at);
    wait_cyc(at + 3);  pulse(M_WALL, at);
    wait_cyc(at + 3);  pulse(M_WALL, at);
    expect_grant(2'd0, g + T_DUR_LONG + T_GAP + 1);
    wait_idle("merge", 200);

    // Mute mid-tone while paddle is pending. A strobe during mute is
    // ignored, so nothing plays afterwards.
    pulse(M_MISS, at);
    g = at + 2;
    expect_grant(2'd2, g);
    wait_cyc(g + 3);
    pulse(M_PADDLE, at);
    wait_cyc(g + 11);
    check("mute_pre_tone", 32'(tone_out), 32'd1);
    mute = 1'b1;
    @(negedge clk_0);
    check("mute_tone", 32'(tone_out), 32'd0);
    check("mute_busy", 32'(busy), 32'd0);
    pulse(M_WALL, at);
    mute = 1'b0;
    repeat (60) @(negedge clk_0);
    check("mute_after_busy", 32'(busy), 32'd0);
    check("mute_after_tone", 32'(tone_out), 32'd0);
    check("mute_hold_id", 32'(active_id), 32'd2);
    check("mute_no_grant", 32'(sb.size()), 32'd0);
    pulse(M_PADDLE, at);
    expect_grant(2'd1, at + 2);
    wait_idle("post_mute", 100);

    // Asynchronous reset mid-tone discards the tone and a pending wall.
    pulse(M_OVER, at);
    g = at + 2;
    expect_grant(2'd3, g);
    wait_cyc(g + 2);
    pulse(M_WALL, at);
    wait_cyc(g + 4);
    check("rst_mid_pre_tone", 32'(tone_out), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("rst_mid_tone", 32'(tone_out), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_grant", 32'(grant), 32'd0);
    check("rst_mid_id", 32'(active_id), 32'd0);
    @(negedge clk_0);
    rst = 1'b1;
    repeat (70) @(negedge clk_0);
    check("rst_lost_busy", 32'(busy), 32'd0);
    pulse(M_PADDLE, at);
    expect_grant(2'd1, at + 2);
    wait_idle("post_rst", 100);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
